// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, fetch FSM state type and default reset PC.
package cpu_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HELD = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters (delivered fetches, hold cycles); wrapping, async active-low reset.
// Compiled only when IF_FETCH_PERF_EN is defined.
`ifdef IF_FETCH_PERF_EN
module fetch_perf_ctr (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_evt_i,
    input  logic        hold_evt_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] hold_cnt_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o <= 32'd0;
            hold_cnt_o  <= 32'd0;
        end else begin
            if (fetch_evt_i) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (hold_evt_i)  hold_cnt_o  <= hold_cnt_o + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack fetch FSM, stall buffering and branch redirect.
// Optional perf counters (perf_fetch_cnt_o, perf_hold_cnt_o) when IF_FETCH_PERF_EN is defined.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         stall_i,
    input  logic         branch_i,
    input  logic [31:0]  branch_target_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_ack_i,
    input  logic [31:0]  imem_rdata_i,
    output logic [31:0]  add_pc_o,
    output logic [31:0]  inst_o,
    output logic         fetch_hold_o,
    output fetch_state_t state_o
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt_o,
    output logic [31:0]  perf_hold_cnt_o
`endif
);

    // Handshake: a transfer completes in any cycle with imem_req_o && imem_ack_i; the
    // address is held until then, and ack may arrive combinationally in the request cycle.
    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_buf_q, inst_buf_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  inst;
    logic         req;
    logic         hold;

    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            inst_buf_q <= NOP_INST;
            redir_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        redir_pc_d = redir_pc_q;
        req        = 1'b0;
        inst       = NOP_INST;
        hold       = 1'b1;
        case (state_q)
            S_REQ: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    inst = imem_rdata_i;
                    hold = 1'b0;
                end
                if (branch_i && imem_ack_i) begin
                    pc_d = branch_target_i;
                end else if (branch_i) begin
                    redir_pc_d = branch_target_i;
                    state_d    = S_DROP;
                end else if (imem_ack_i && stall_i) begin
                    inst_buf_d = imem_rdata_i;
                    state_d    = S_HELD;
                end else if (imem_ack_i) begin
                    pc_d = pc_plus4;
                end
            end
            S_HELD: begin
                inst = inst_buf_q;
                hold = 1'b0;
                if (branch_i) begin
                    pc_d    = branch_target_i;
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                // Abandoned request must still complete; a branch arriving now wins over redir_pc_q.
                req = 1'b1;
                if (branch_i) redir_pc_d = branch_target_i;
                if (imem_ack_i) begin
                    pc_d    = branch_i ? branch_target_i : redir_pc_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
        if (!rst_i) begin
            req  = 1'b0;
            inst = NOP_INST;
            hold = 1'b1;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = pc_q;
    assign add_pc_o     = pc_plus4;
    assign inst_o       = inst;
    assign fetch_hold_o = hold;
    assign state_o      = state_q;

`ifdef IF_FETCH_PERF_EN
    logic fetch_evt;

    assign fetch_evt = rst_i && (state_q == S_REQ) && imem_ack_i;

    fetch_perf_ctr u_perf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fetch_evt_i (fetch_evt),
        .hold_evt_i  (hold),
        .fetch_cnt_o (perf_fetch_cnt_o),
        .hold_cnt_o  (perf_hold_cnt_o)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run against a
// pipeline-level reference model. Perf counters are exercised when IF_FETCH_PERF_EN is defined.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         stall;
    logic         branch;
    logic [31:0]  target;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [31:0]  add_pc;
    logic [31:0]  inst;
    logic         hold;
    fetch_state_t dbg_state;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]  perf_fetch_cnt;
    logic [31:0]  perf_hold_cnt;
`endif

    int cfg_wait;
    int wait_ctr;
    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ a ^ 32'h5A5A_C3C3;
    endfunction

    // Memory model: acks once the request has waited cfg_wait cycles (0 = same cycle).
    assign imem_ack   = imem_req && (wait_ctr >= cfg_wait);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     wait_ctr <= 0;
        else if (imem_req && imem_ack)  wait_ctr <= 0;
        else if (imem_req)              wait_ctr <= wait_ctr + 1;
    end

    if_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .stall_i         (stall),
        .branch_i        (branch),
        .branch_target_i (target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_rdata_i    (imem_rdata),
        .add_pc_o        (add_pc),
        .inst_o          (inst),
        .fetch_hold_o    (hold),
        .state_o         (dbg_state)
`ifdef IF_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt),
        .perf_hold_cnt_o (perf_hold_cnt)
`endif
    );

    // Advance one cycle, drive this cycle's inputs, then let combinational outputs settle.
    task automatic tick(input logic s, input logic b, input logic [31:0] t, input int w);
        @(posedge clk); #1;
        stall = s; branch = b; target = t; cfg_wait = w;
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        tick(1'b0, 1'b1, a, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'd0; cfg_wait = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (hold !== 1'b1) begin failures++; $display("FAIL rst_hold got=%b exp=1", hold); end
        checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", inst); end
        checks++; if (add_pc !== TB_RESET_PC + 32'd4) begin failures++; $display("FAIL rst_add_pc got=%h exp=%h", add_pc, TB_RESET_PC + 32'd4); end
        checks++; if (dbg_state !== S_REQ) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_REQ); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_a;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1'b0, 1'b0, 32'd0, 0);
            exp_a = TB_RESET_PC + 32'(4 * i);
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req[%0d] got=%b exp=1", i, imem_req); end
            checks++; if (imem_addr !== exp_a) begin failures++; $display("FAIL zw_addr[%0d] got=%h exp=%h", i, imem_addr, exp_a); end
            checks++; if (add_pc !== exp_a + 32'd4) begin failures++; $display("FAIL zw_add_pc[%0d] got=%h exp=%h", i, add_pc, exp_a + 32'd4); end
            checks++; if (hold !== 1'b0) begin failures++; $display("FAIL zw_hold[%0d] got=%b exp=0", i, hold); end
            checks++; if (inst !== mem_word(exp_a)) begin failures++; $display("FAIL zw_inst[%0d] got=%h exp=%h", i, inst, mem_word(exp_a)); end
        end
    endtask

    task automatic test_wait2();
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 1'b0, 32'd0, 2);
            checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL w2_addr[%0d] got=%h exp=10", c, imem_addr); end
            if (c < 2) begin
                checks++; if (hold !== 1'b1 || inst !== 32'h0) begin failures++; $display("FAIL w2_wait[%0d] hold=%b inst=%h exp hold=1 inst=0", c, hold, inst); end
            end else begin
                checks++; if (hold !== 1'b0 || inst !== mem_word(32'h10)) begin failures++; $display("FAIL w2_data hold=%b inst=%h exp hold=0 inst=%h", hold, inst, mem_word(32'h10)); end
                checks++; if (add_pc !== 32'h14) begin failures++; $display("FAIL w2_add_pc got=%h exp=14", add_pc); end
            end
        end
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin failures++; $display("FAIL w2_next req=%b addr=%h exp req=1 addr=14", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        redirect_to(32'h20);
        tick(1'b1, 1'b0, 32'd0, 0);
        checks++; if (imem_addr !== 32'h20 || inst !== mem_word(32'h20) || hold !== 1'b0) begin failures++; $display("FAIL st_ack addr=%h inst=%h hold=%b exp addr=20 inst=%h hold=0", imem_addr, inst, hold, mem_word(32'h20)); end
        for (int c = 0; c < 3; c++) begin
            tick(c < 2, 1'b0, 32'd0, 0);
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_req[%0d] got=%b exp=0", c, imem_req); end
            checks++; if (inst !== mem_word(32'h20) || hold !== 1'b0) begin failures++; $display("FAIL st_inst[%0d] inst=%h hold=%b exp inst=%h hold=0", c, inst, hold, mem_word(32'h20)); end
            checks++; if (add_pc !== 32'h24) begin failures++; $display("FAIL st_add_pc[%0d] got=%h exp=24", c, add_pc); end
            checks++; if (dbg_state !== S_HELD) begin failures++; $display("FAIL st_state[%0d] got=%0d exp=%0d", c, dbg_state, S_HELD); end
        end
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin failures++; $display("FAIL st_next req=%b addr=%h exp req=1 addr=24", imem_req, imem_addr); end
    endtask

    task automatic test_branch_drop();
        redirect_to(32'h40);
        tick(1'b0, 1'b0, 32'd0, 3);
        tick(1'b0, 1'b1, 32'h100, 3);
        checks++; if (imem_addr !== 32'h40 || hold !== 1'b1) begin failures++; $display("FAIL bd_br addr=%h hold=%b exp addr=40 hold=1", imem_addr, hold); end
        for (int c = 0; c < 2; c++) begin
            tick(1'b0, 1'b0, 32'd0, 3);
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin failures++; $display("FAIL bd_addr[%0d] req=%b addr=%h exp req=1 addr=40", c, imem_req, imem_addr); end
            checks++; if (inst !== 32'h0 || hold !== 1'b1) begin failures++; $display("FAIL bd_drop[%0d] inst=%h hold=%b exp inst=0 hold=1", c, inst, hold); end
            checks++; if (dbg_state !== S_DROP) begin failures++; $display("FAIL bd_state[%0d] got=%0d exp=%0d", c, dbg_state, S_DROP); end
        end
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_addr !== 32'h100 || inst !== mem_word(32'h100)) begin failures++; $display("FAIL bd_target addr=%h inst=%h exp addr=100 inst=%h", imem_addr, inst, mem_word(32'h100)); end
    endtask

    task automatic test_drop_retarget();
        redirect_to(32'h60);
        tick(1'b0, 1'b1, 32'h200, 2);
        tick(1'b0, 1'b1, 32'h300, 2);
        checks++; if (imem_addr !== 32'h60) begin failures++; $display("FAIL rt_addr got=%h exp=60", imem_addr); end
        tick(1'b0, 1'b0, 32'd0, 2);
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL rt_latest got=%h exp=300", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_addr !== 32'hFFFF_FFFC || add_pc !== 32'h0) begin failures++; $display("FAIL wr_top addr=%h add_pc=%h exp addr=fffffffc add_pc=0", imem_addr, add_pc); end
        tick(1'b0, 1'b0, 32'd0, 0);
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wr_next got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_mid();
        redirect_to(32'h80);
        tick(1'b0, 1'b0, 32'd0, 5);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || hold !== 1'b1 || inst !== 32'h0) begin failures++; $display("FAIL rm_out req=%b hold=%b inst=%h exp req=0 hold=1 inst=0", imem_req, hold, inst); end
        checks++; if (add_pc !== TB_RESET_PC + 32'd4 || dbg_state !== S_REQ) begin failures++; $display("FAIL rm_state add_pc=%h state=%0d exp add_pc=%h state=%0d", add_pc, dbg_state, TB_RESET_PC + 32'd4, S_REQ); end
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_wait = 0;
        #1;
        checks++; if (imem_addr !== TB_RESET_PC || hold !== 1'b0) begin failures++; $display("FAIL rm_release addr=%h hold=%b exp addr=%h hold=0", imem_addr, hold, TB_RESET_PC); end
    endtask

    // Model: a presented instruction (hold=0) is consumed when not stalled; a branch makes the
    // target the next instruction to be presented, whatever the fetch was doing.
    task automatic test_random();
        logic        s, b;
        logic [31:0] t, cur, prev_addr;
        logic        prev_pending;
        int          delivered;
        delivered = 0;
        prev_pending = 1'b0;
        prev_addr = 32'd0;
        redirect_to(32'h1000);
        exp_q.delete();
        exp_q.push_back(32'h1000);
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 9) == 0);
            t = $urandom;
            tick(s, b, t, $urandom_range(0, 3));
            if (prev_pending && imem_req) begin
                checks++; if (imem_addr !== prev_addr) begin failures++; $display("FAIL rnd_addr_stable[%0d] got=%h exp=%h", n, imem_addr, prev_addr); end
            end
            if (!hold) begin
                delivered++;
                checks++; if (inst !== mem_word(exp_q[0])) begin failures++; $display("FAIL rnd_inst[%0d] got=%h exp=%h", n, inst, mem_word(exp_q[0])); end
                checks++; if (add_pc !== exp_q[0] + 32'd4) begin failures++; $display("FAIL rnd_add_pc[%0d] got=%h exp=%h", n, add_pc, exp_q[0] + 32'd4); end
            end else begin
                checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rnd_nop[%0d] got=%h exp=0", n, inst); end
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (b) begin
                exp_q.delete();
                exp_q.push_back(t);
            end else if (!hold && !s) begin
                cur = exp_q.pop_front();
                exp_q.push_back(cur + 32'd4);
            end
        end
        checks++; if (delivered < 40) begin failures++; $display("FAIL rnd_progress got=%0d exp>=40", delivered); end
        stall = 1'b0; branch = 1'b0;
    endtask

`ifdef IF_FETCH_PERF_EN
    task automatic test_perf();
        int waits[8];
        waits = '{0, 1, 1, 2, 2, 2, 0, 0};
        @(posedge clk); #1;
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0;
        #1;
        checks++; if (perf_fetch_cnt !== 32'd0 || perf_hold_cnt !== 32'd0) begin failures++; $display("FAIL pf_reset fetch=%0d hold=%0d exp 0 0", perf_fetch_cnt, perf_hold_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1; cfg_wait = waits[0];
        for (int i = 1; i < 8; i++) tick(1'b0, 1'b0, 32'd0, waits[i]);
        @(posedge clk); #1;
        cfg_wait = 0;
        checks++; if (perf_fetch_cnt !== 32'd5) begin failures++; $display("FAIL pf_fetch got=%0d exp=5", perf_fetch_cnt); end
        checks++; if (perf_hold_cnt !== 32'd3) begin failures++; $display("FAIL pf_hold got=%0d exp=3", perf_hold_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_stall();
        test_branch_drop();
        test_drop_retarget();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef IF_FETCH_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
